// File: rtl/haz_pkg.sv
// Shared field positions, slot descriptor and decode helper for the hazard
// detector and its FSM companion.
package haz_pkg;

  localparam int unsigned NREG_DEFAULT = 4;
  localparam int unsigned REG_W        = 2;

  localparam int unsigned UI_VALID  = 0;
  localparam int unsigned UI_LOAD   = 1;
  localparam int unsigned UI_MEM    = 2;
  localparam int unsigned UI_BRANCH = 3;
  localparam int unsigned UI_PRED   = 4;
  localparam int unsigned UI_WRITES = 5;
  localparam int unsigned UI_STALL  = 6;
  localparam int unsigned UI_FLUSH  = 7;

  localparam int unsigned UIO_RD_LO   = 0;
  localparam int unsigned UIO_RS1_LO  = 2;
  localparam int unsigned UIO_RS2_LO  = 4;
  localparam int unsigned UIO_RESOLVE = 6;
  localparam int unsigned UIO_TAKEN   = 7;

  localparam int unsigned UO_DATA     = 7;
  localparam int unsigned UO_STR      = 6;
  localparam int unsigned UO_CTRL     = 5;
  localparam int unsigned UO_BRANCH   = 4;
  localparam int unsigned UO_FWRD     = 3;
  localparam int unsigned UO_CRCT     = 2;
  localparam int unsigned UO_PROTO    = 1;
  localparam int unsigned UO_ID_VALID = 0;

  typedef struct packed {
    logic             valid;
    logic             is_load;
    logic             mem_access;
    logic             is_branch;
    logic             pred_taken;
    logic             writes_rd;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } slot_t;

  // Invalid instructions collapse to an all-zero bubble.
  function automatic slot_t decode(input logic [7:0] ui, input logic [7:0] uio);
    slot_t s;
    s = '0;
    if (ui[UI_VALID]) begin
      s.valid      = 1'b1;
      s.is_load    = ui[UI_LOAD];
      s.mem_access = ui[UI_MEM];
      s.is_branch  = ui[UI_BRANCH];
      s.pred_taken = ui[UI_PRED];
      s.writes_rd  = ui[UI_WRITES];
      s.rd         = uio[UIO_RD_LO  +: REG_W];
      s.rs1        = uio[UIO_RS1_LO +: REG_W];
      s.rs2        = uio[UIO_RS2_LO +: REG_W];
    end
    return s;
  endfunction

endpackage

// File: rtl/haz_slot.sv
// One shadow-pipeline stage register; exposes its next value so flags can be
// registered in the same edge the slot updates.
module haz_slot
  import haz_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  bubble,
  input  logic  hold,
  input  slot_t d,
  output slot_t q,
  output slot_t nxt_c
);

  // Bubble wins over hold, hold wins over load.
  always_comb begin
    nxt_c = q;
    if (bubble)      nxt_c = '0;
    else if (hold)   nxt_c = q;
    else if (load)   nxt_c = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= nxt_c;
  end

endmodule

// File: rtl/tt_um_haz_detect.sv
// Hazard detector: tracks ID/EX/MEM shadow slots and reports data, structural
// and control hazards with one cycle of latency.
module tt_um_haz_detect
  import haz_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  slot_t id_d, id_q, id_n, ex_q, ex_n, mem_q, mem_n;
  logic  stall, flush, resolve, taken;
  logic  bp_q, bp_n, pp_q, pp_n, perr_q, perr_n;
  logic  ex_hit_c, mem_hit_c, br_enter_c, branch_c;
  logic [7:0] flags_c;
  logic  unused_c;

  assign stall    = ui_in[UI_STALL];
  assign flush    = ui_in[UI_FLUSH];
  assign resolve  = uio_in[UIO_RESOLVE];
  assign taken    = uio_in[UIO_TAKEN];
  assign id_d     = decode(ui_in, uio_in);
  assign uio_out  = 8'h00;
  assign uio_oe   = 8'h00;
  assign unused_c = ena;

  haz_slot u_id (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .bubble(flush), .hold(stall),
    .d(id_d), .q(id_q), .nxt_c(id_n)
  );

  haz_slot u_ex (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .bubble(flush | stall), .hold(1'b0),
    .d(id_q), .q(ex_q), .nxt_c(ex_n)
  );

  haz_slot u_mem (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .bubble(1'b0), .hold(1'b0),
    .d(ex_q), .q(mem_q), .nxt_c(mem_n)
  );

  // A producer matters only if it writes a real, non-zero register.
  function automatic logic produces(input slot_t p, input slot_t c);
    return p.valid && p.writes_rd && (p.rd != REG_W'(0)) && (32'(p.rd) < NREG)
           && ((p.rd == c.rs1) || (p.rd == c.rs2));
  endfunction

  always_comb begin
    ex_hit_c   = id_n.valid && produces(ex_n, id_n);
    mem_hit_c  = id_n.valid && produces(mem_n, id_n);
    br_enter_c = ex_n.valid && ex_n.is_branch;
    branch_c   = resolve && bp_q;

    bp_n = bp_q;
    pp_n = pp_q;
    if (br_enter_c) begin
      bp_n = 1'b1;
      pp_n = ex_n.pred_taken;
    end else if (resolve || flush) begin
      bp_n = 1'b0;
    end
    perr_n = perr_q || (resolve && !bp_q);

    flags_c              = 8'h00;
    flags_c[UO_DATA]     = ex_hit_c || mem_hit_c;
    flags_c[UO_FWRD]     = (ex_hit_c || mem_hit_c) && !(ex_hit_c && ex_n.is_load);
    flags_c[UO_STR]      = id_n.valid && id_n.mem_access && mem_n.valid && mem_n.mem_access;
    flags_c[UO_CTRL]     = (id_n.valid && id_n.is_branch) || bp_n;
    flags_c[UO_BRANCH]   = branch_c;
    flags_c[UO_CRCT]     = branch_c && (pp_q == taken);
    flags_c[UO_PROTO]    = perr_n;
    flags_c[UO_ID_VALID] = id_n.valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bp_q   <= 1'b0;
      pp_q   <= 1'b0;
      perr_q <= 1'b0;
      uo_out <= 8'h00;
    end else begin
      bp_q   <= bp_n;
      pp_q   <= pp_n;
      perr_q <= perr_n;
      uo_out <= flags_c;
    end
  end

endmodule

// File: tb/tb_tt_um_haz_detect.sv
// Directed hazard scenarios followed by random traffic, all checked against a
// behavioural pipeline model.
module tb_tt_um_haz_detect;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_um_haz_detect dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  typedef struct packed {
    bit v, ld, mem, br, pt, wr;
    bit [1:0] rd, rs1, rs2;
  } ins_t;

  ins_t pipe [3];           // 0 = ID, 1 = EX, 2 = MEM
  bit   pend, pend_pt, perr;
  logic [7:0] exp_uo;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {7'b0, obs}, {7'b0, exp});
  endtask

  task automatic model_step(input logic r, input logic [7:0] u, input logic [7:0] uv);
    ins_t n;
    bit res, tk, brk, crc, data, ex_load_hit, str, ctrl;
    n = '0;
    if (u[0]) begin
      n.v = 1; n.ld = u[1]; n.mem = u[2]; n.br = u[3]; n.pt = u[4]; n.wr = u[5];
      n.rd = uv[1:0]; n.rs1 = uv[3:2]; n.rs2 = uv[5:4];
    end
    if (!r) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      pend = 0; pend_pt = 0; perr = 0; exp_uo = 8'h00;
      return;
    end
    res = uv[6];
    tk  = uv[7];
    brk = res && pend;
    crc = brk && (pend_pt == tk);
    if (res && !pend) perr = 1;
    pipe[2] = pipe[1];
    if (u[7]) begin
      pipe[0] = '0; pipe[1] = '0;
    end else if (u[6]) begin
      pipe[1] = '0;
    end else begin
      pipe[1] = pipe[0]; pipe[0] = n;
    end
    if (pipe[1].v && pipe[1].br) begin
      pend = 1; pend_pt = pipe[1].pt;
    end else if (res || u[7]) begin
      pend = 0;
    end
    data = 0; ex_load_hit = 0;
    for (int p = 1; p <= 2; p++)
      if (pipe[0].v && pipe[p].v && pipe[p].wr && pipe[p].rd != 0 &&
          (pipe[p].rd == pipe[0].rs1 || pipe[p].rd == pipe[0].rs2)) begin
        data = 1;
        if (p == 1 && pipe[p].ld) ex_load_hit = 1;
      end
    str  = pipe[0].v && pipe[0].mem && pipe[2].v && pipe[2].mem;
    ctrl = (pipe[0].v && pipe[0].br) || pend;
    exp_uo = {data, str, ctrl, brk, data && !ex_load_hit, crc, perr, pipe[0].v};
  endtask

  task automatic cycle(input logic r, input logic [7:0] u, input logic [7:0] uv);
    rst_n  = r;
    ui_in  = u;
    uio_in = uv;
    @(posedge clk);
    #1;
    model_step(r, u, uv);
    check("uo_out", uo_out, exp_uo);
    check("uio_out", uio_out | uio_oe, 8'h00);
  endtask

  initial begin
    logic [7:0] ru, rv;
    logic       rr;

    cycle(0, 8'hFF, 8'hFF);
    cycle(0, 8'h00, 8'h00);
    check("reset_uo", uo_out, 8'h00);

    // RAW forwardable: ALU writes r2, next reads r2
    cycle(1, 8'h21, 8'h02);
    cycle(1, 8'h01, 8'h08);
    check_bit("raw_data", uo_out[7], 1'b1);
    check_bit("raw_fwrd", uo_out[3], 1'b1);
    cycle(1, 8'h00, 8'h00);
    cycle(1, 8'h00, 8'h00);

    // Load-use, then one stall cycle
    cycle(1, 8'h27, 8'h03);
    cycle(1, 8'h01, 8'h30);
    check_bit("lu_data", uo_out[7], 1'b1);
    check_bit("lu_fwrd", uo_out[3], 1'b0);
    cycle(1, 8'h40, 8'h00);
    check_bit("lu_stall_data", uo_out[7], 1'b1);
    check_bit("lu_stall_fwrd", uo_out[3], 1'b1);
    cycle(1, 8'h00, 8'h00);
    cycle(1, 8'h00, 8'h00);

    // r0 is never a dependency
    cycle(1, 8'h21, 8'h00);
    cycle(1, 8'h01, 8'h00);
    check_bit("r0_data", uo_out[7], 1'b0);
    cycle(1, 8'h00, 8'h00);
    cycle(1, 8'h00, 8'h00);

    // Structural: load, bubble, store
    cycle(1, 8'h27, 8'h03);
    cycle(1, 8'h00, 8'h00);
    cycle(1, 8'h05, 8'h00);
    check_bit("str_hit", uo_out[6], 1'b1);
    cycle(1, 8'h00, 8'h00);
    check_bit("str_clear", uo_out[6], 1'b0);
    cycle(1, 8'h00, 8'h00);

    // Mispredicted branch resolved together with a flush
    cycle(1, 8'h19, 8'h00);
    check_bit("br_id_ctrl", uo_out[5], 1'b1);
    cycle(1, 8'h00, 8'h00);
    check_bit("br_pend_ctrl", uo_out[5], 1'b1);
    cycle(1, 8'h80, 8'h40);
    check("br_resolve", uo_out & 8'h35, 8'h10);
    cycle(1, 8'h00, 8'h00);
    check_bit("br_one_cycle", uo_out[4], 1'b0);

    // Correct prediction
    cycle(1, 8'h19, 8'h00);
    cycle(1, 8'h00, 8'h00);
    cycle(1, 8'h00, 8'hC0);
    check("br_correct", uo_out & 8'h14, 8'h14);

    // Stray resolve is sticky until reset, and right after reset too
    cycle(1, 8'h00, 8'h40);
    check_bit("proto_set", uo_out[1], 1'b1);
    for (int i = 0; i < 3; i++) cycle(1, 8'h00, 8'h00);
    check_bit("proto_sticky", uo_out[1], 1'b1);
    cycle(0, 8'h00, 8'h00);
    check_bit("proto_reset", uo_out[1], 1'b0);
    cycle(1, 8'h19, 8'h00);
    cycle(1, 8'h00, 8'h00);
    cycle(0, 8'h00, 8'h00);
    cycle(1, 8'h00, 8'h40);
    check("post_reset_resolve", uo_out, 8'h02);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ru    = 8'($urandom);
      rv    = 8'($urandom);
      ru[7] = ($urandom_range(0, 7) == 0);
      ru[6] = ($urandom_range(0, 4) == 0);
      rv[6] = ($urandom_range(0, 3) == 0);
      rr    = ($urandom_range(0, 39) != 0);
      cycle(rr, ru, rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
